// File: rtl/arm_pkg.sv
// Shared ARM pipeline definitions: word width, bubble word, reset PC and the IF/ID record.
// Used by fetch_stage and if_id_register.
package arm_pkg;

    localparam int          WORD_W    = 32;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
    localparam logic [31:0] PC_RESET  = 32'h0000_0000;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instruction;
        logic              valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{pc: '0, instruction: INSTR_NOP, valid: 1'b0};

    // Branch targets are word addresses; the two byte-offset bits are dropped.
    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register. Priority: rst > flush > freeze > load.
module if_id_register
    import arm_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    input  logic   freeze,
    input  if_id_t load_data,
    output if_id_t q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= IF_ID_BUBBLE;
        end else if (flush) begin
            q <= IF_ID_BUBBLE;
        end else if (!freeze) begin
            q <= load_data;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC mux and IF/ID register.
// Optional perf counters (fetch_count, flush_count) under IF_PERF_COUNTERS_EN.
module fetch_stage
    import arm_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PC_RESET,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_address,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instruction,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instruction,
    output logic        if_id_valid
`ifdef IF_PERF_COUNTERS_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] flush_count
`endif
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_plus_step;
    if_id_t      if_id_load;
    if_id_t      if_id_q;

    assign pc_plus_step = pc + STEP;
    assign imem_addr    = pc;

    // A branch overrides a freeze; a frozen PC keeps re-reading the same word.
    always_comb begin
        pc_next = pc_plus_step;
        if (branch_taken) begin
            pc_next = word_align(branch_address);
        end else if (freeze) begin
            pc_next = pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    always_comb begin
        if_id_load             = IF_ID_BUBBLE;
        if_id_load.pc          = pc_plus_step;
        if_id_load.instruction = imem_instruction;
        if_id_load.valid       = 1'b1;
    end

    if_id_register u_if_id (
        .clk       (clk),
        .rst       (rst),
        .flush     (branch_taken),
        .freeze    (freeze),
        .load_data (if_id_load),
        .q         (if_id_q)
    );

    assign if_id_pc          = if_id_q.pc;
    assign if_id_instruction = if_id_q.instruction;
    assign if_id_valid       = if_id_q.valid;

`ifdef IF_PERF_COUNTERS_EN
    // Counts mirror the IF/ID priority: a flush edge is never also a fetch edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= '0;
            flush_count <= '0;
        end else if (branch_taken) begin
            flush_count <= flush_count + 32'd1;
        end else if (!freeze) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed test-plan steps, then randomized traffic
// against a behavioural model. Counter checks are enabled with IF_PERF_COUNTERS_EN.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic [31:0] imem_addr;
    logic [31:0] imem_instruction;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instruction;
    logic        if_id_valid;
`ifdef IF_PERF_COUNTERS_EN
    logic [31:0] fetch_count;
    logic [31:0] flush_count;
`endif

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    logic [31:0] m_if_pc;
    logic [31:0] m_instr;
    logic        m_valid;
    logic [31:0] m_fetches;
    logic [31:0] m_flushes;

    fetch_stage #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .freeze            (freeze),
        .branch_taken      (branch_taken),
        .branch_address    (branch_address),
        .imem_addr         (imem_addr),
        .imem_instruction  (imem_instruction),
        .if_id_pc          (if_id_pc),
        .if_id_instruction (if_id_instruction),
        .if_id_valid       (if_id_valid)
`ifdef IF_PERF_COUNTERS_EN
        ,
        .fetch_count       (fetch_count),
        .flush_count       (flush_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory contents: two fixed words, everything else a scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'h0000_0000) return 32'hE3A0_0014;
        if (addr == 32'h0000_0004) return 32'hE3A0_1A01;
        return {addr[15:0] ^ 16'hA5C3, addr[31:16] ^ 16'h1E0F};
    endfunction

    assign imem_instruction = mem_word(imem_addr);

    task automatic check32(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        check32({tag, ".imem_addr"}, imem_addr, m_pc);
        check32({tag, ".if_id_pc"}, if_id_pc, m_if_pc);
        check32({tag, ".if_id_instruction"}, if_id_instruction, m_instr);
        check32({tag, ".if_id_valid"}, {31'd0, if_id_valid}, {31'd0, m_valid});
`ifdef IF_PERF_COUNTERS_EN
        check32({tag, ".fetch_count"}, fetch_count, m_fetches);
        check32({tag, ".flush_count"}, flush_count, m_flushes);
`endif
    endtask

    // Drive one cycle of inputs, advance the model by the stage's rules, then check after the edge.
    task automatic applyStimulus(input logic r, input logic frz, input logic br,
                                 input logic [31:0] addr, input string tag);
        rst            = r;
        freeze         = frz;
        branch_taken   = br;
        branch_address = addr;
        if (r) begin
            m_pc = 32'h0; m_if_pc = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
            m_fetches = 32'h0; m_flushes = 32'h0;
        end else if (br) begin
            m_pc = {addr[31:2], 2'b00};
            m_if_pc = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
            m_flushes = m_flushes + 1;
        end else if (!frz) begin
            m_instr = mem_word(m_pc);
            m_pc = m_pc + 32'd4;
            m_if_pc = m_pc;
            m_valid = 1'b1;
            m_fetches = m_fetches + 1;
        end
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_address = 32'h0;
        m_pc = 32'h0; m_if_pc = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
        m_fetches = 32'h0; m_flushes = 32'h0;

        // Reset, with freeze/branch and garbage memory ignored
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h1234_5678, "reset0");
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, "reset1");
        check32("reset_imem_addr", imem_addr, 32'h0);
        check32("reset_valid", {31'd0, if_id_valid}, 32'd0);

        // Sequential fetch from 0
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, "fetch0");
        check32("tp_word0", if_id_instruction, 32'hE3A0_0014);
        check32("tp_pc0", if_id_pc, 32'h4);
        check32("tp_addr4", imem_addr, 32'h4);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, "fetch1");
        check32("tp_word1", if_id_instruction, 32'hE3A0_1A01);
        check32("tp_pc1", if_id_pc, 32'h8);
        check32("tp_addr8", imem_addr, 32'h8);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, "fetch2");

        // Freeze 3 cycles at PC=12
        check32("tp_pc12", imem_addr, 32'hC);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, "freeze");
        check32("tp_frozen_addr", imem_addr, 32'hC);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, "unfreeze");
        check32("tp_unfreeze_pc", if_id_pc, 32'h10);
        check32("tp_unfreeze_word", if_id_instruction, mem_word(32'hC));

        // Run to PC=40 then branch to 0x93
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, "run");
        check32("tp_pc40", imem_addr, 32'h28);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0093, "branch");
        check32("tp_branch_addr", imem_addr, 32'h90);
        check32("tp_branch_bubble", {31'd0, if_id_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, "after_branch");
        check32("tp_target_pc", if_id_pc, 32'h94);
        check32("tp_target_word", if_id_instruction, mem_word(32'h90));

        // Branch beats freeze
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0200, "branch_freeze");
        check32("tp_bf_addr", imem_addr, 32'h200);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, "after_bf");

        // Wrap at top of address space
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, "branch_top");
        check32("tp_top_addr", imem_addr, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, "wrap");
        check32("tp_wrap_addr", imem_addr, 32'h0);
        check32("tp_wrap_if_pc", if_id_pc, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 7) == 0), $urandom, "random");
        end

        // Counter scenario: 10 fetches, 2 branches, 3 freeze cycles
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, "cnt_reset");
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, "cnt_fetch_a");
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0400, "cnt_branch_a");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, "cnt_freeze");
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, "cnt_fetch_b");
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0800, "cnt_branch_b");
`ifdef IF_PERF_COUNTERS_EN
        check32("tp_fetch_count", fetch_count, 32'd10);
        check32("tp_flush_count", flush_count, 32'd2);
`endif
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0C00, "cnt_mid_reset");
`ifdef IF_PERF_COUNTERS_EN
        check32("tp_fetch_count_rst", fetch_count, 32'd0);
        check32("tp_flush_count_rst", flush_count, 32'd0);
`endif
        check32("tp_mid_reset_addr", imem_addr, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
